// File: rtl/db_arbiter.sv
// rtl/db_arbiter.sv - round-robin N-master DataBus arbiter with per-transaction timeout
module db_arbiter #(
    parameter int          NUM_MASTERS = 2,
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          TIMEOUT     = 1024,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic [NUM_MASTERS-1:0]        m_re,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS-1:0]        m_io,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dataOut,
    output logic [DATA_W-1:0]             m_dataIn,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic                          s_re,
    output logic                          s_we,
    output logic                          s_io,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_dataOut,
    input  logic [DATA_W-1:0]             s_dataIn,
    input  logic                          s_ready,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          timeout_err,
    output logic [$clog2(NUM_MASTERS)-1:0] err_id
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          err_id_q, err_id_d;

    logic [NUM_MASTERS-1:0] req;
    logic [IW-1:0]          pick;
    logic                   found;
    logic                   tmo_hit;

    assign req     = m_re | m_we;
    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    assign grant   = grant_q;
    assign err_id  = err_id_q;

    // Round-robin search: first requester after the last completed owner
    always_comb begin
        int idx;
        idx   = 0;
        pick  = rr_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(rr_q) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Next-state logic and slave/master-side muxing; outputs are zero outside BUSY
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        err_id_d    = err_id_q;
        s_re        = 1'b0;
        s_we        = 1'b0;
        s_io        = 1'b0;
        s_addr      = '0;
        s_dataOut   = '0;
        m_ready     = '0;
        m_dataIn    = '0;
        timeout_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    gidx_d        = pick;
                    cnt_d         = '0;
                    state_d       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_re      = m_re[gidx_q];
                s_we      = m_we[gidx_q];
                s_io      = m_io[gidx_q];
                s_addr    = m_addr[gidx_q*ADDR_W +: ADDR_W];
                s_dataOut = m_dataOut[gidx_q*DATA_W +: DATA_W];
                m_dataIn  = s_dataIn;
                if (!req[gidx_q]) begin
                    // Owner withdrew without a completion: release the bus, keep priority order
                    state_d = ST_GAP;
                    grant_d = '0;
                end else if (s_ready) begin
                    m_ready = grant_q;
                    rr_d    = gidx_q;
                    state_d = ST_GAP;
                    grant_d = '0;
                end else if (tmo_hit) begin
                    m_ready     = grant_q;
                    m_dataIn    = DATA_W'(ERR_DATA);
                    timeout_err = 1'b1;
                    err_id_d    = gidx_q;
                    rr_d        = gidx_q;
                    state_d     = ST_GAP;
                    grant_d     = '0;
                end else if ((TIMEOUT > 0) && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; rr starts at N-1 so master 0 wins the first arbitration
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_q     <= IW'(NUM_MASTERS - 1);
            cnt_q    <= '0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            err_id_q <= err_id_d;
        end
    end

endmodule

// File: tb/tb_db_arbiter.sv
// tb/tb_db_arbiter.sv - directed table and sequence checks for db_arbiter
module tb_db_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            res_n;
    logic [N-1:0]    m_re, m_we, m_io;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_dataOut;
    logic [DW-1:0]   m_dataIn;
    logic [N-1:0]    m_ready;
    logic            s_re, s_we, s_io;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_dataOut;
    logic [DW-1:0]   s_dataIn;
    logic            s_ready;
    logic [N-1:0]    grant;
    logic            timeout_err;
    logic [1:0]      err_id;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0]  re, we, io;
        logic        srdy;
        logic [31:0] sdin;
        logic [2:0]  grant_e;
        logic        sre_e, swe_e, sio_e;
        logic [31:0] saddr_e;
        logic [2:0]  mrdy_e;
        logic [31:0] mdin_e;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    db_arbiter #(
        .NUM_MASTERS(N),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .TIMEOUT    (TO),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .m_re       (m_re),
        .m_we       (m_we),
        .m_io       (m_io),
        .m_addr     (m_addr),
        .m_dataOut  (m_dataOut),
        .m_dataIn   (m_dataIn),
        .m_ready    (m_ready),
        .s_re       (s_re),
        .s_we       (s_we),
        .s_io       (s_io),
        .s_addr     (s_addr),
        .s_dataOut  (s_dataOut),
        .s_dataIn   (s_dataIn),
        .s_ready    (s_ready),
        .grant      (grant),
        .timeout_err(timeout_err),
        .err_id     (err_id)
    );

    function automatic vec_t mk(input logic [2:0] re, input logic [2:0] we, input logic [2:0] io,
                                input logic srdy, input logic [31:0] sdin,
                                input logic [2:0] g, input logic sre, input logic swe, input logic sio,
                                input logic [31:0] saddr, input logic [2:0] mrdy, input logic [31:0] mdin);
        vec_t v;
        v.re = re; v.we = we; v.io = io; v.srdy = srdy; v.sdin = sdin;
        v.grant_e = g; v.sre_e = sre; v.swe_e = swe; v.sio_e = sio;
        v.saddr_e = saddr; v.mrdy_e = mrdy; v.mdin_e = mdin;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic [2:0] re, input logic [2:0] we, input logic [2:0] io,
                         input logic rdy, input logic [31:0] din);
        m_re = re; m_we = we; m_io = io; s_ready = rdy; s_dataIn = din;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,         3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[1]  = mk(3'b001, 3'b000, 3'b000, 1'b0, 32'h0,         3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[2]  = mk(3'b001, 3'b000, 3'b000, 1'b0, 32'h5555_0000, 3'b001, 1, 0, 0, 32'h100, 3'b000, 32'h5555_0000);
        tbl[3]  = mk(3'b001, 3'b000, 3'b000, 1'b1, 32'h1234_5678, 3'b001, 1, 0, 0, 32'h100, 3'b001, 32'h1234_5678);
        tbl[4]  = mk(3'b000, 3'b000, 3'b000, 1'b1, 32'h1234_5678, 3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[5]  = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[6]  = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b010, 0, 1, 1, 32'h200, 3'b010, 32'hAAAA_0001);
        tbl[7]  = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[8]  = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[9]  = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b001, 1, 0, 0, 32'h100, 3'b001, 32'hAAAA_0001);
        tbl[10] = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[11] = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[12] = mk(3'b001, 3'b010, 3'b010, 1'b1, 32'hAAAA_0001, 3'b010, 0, 1, 1, 32'h200, 3'b010, 32'hAAAA_0001);
        tbl[13] = mk(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,         3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);
        tbl[14] = mk(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,         3'b000, 0, 0, 0, 32'h0,   3'b000, 32'h0);

        m_addr    = {32'h300, 32'h200, 32'h100};
        m_dataOut = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        res_n     = 1'b0;
        drive(3'b111, 3'b000, 3'b000, 1'b1, 32'h99);

        // Reset state with requests and a ready already present
        next_cycle;
        next_cycle;
        settle;
        chk("rst grant", 32'(grant), 32'h0);
        chk("rst s_re", 32'(s_re), 32'h0);
        chk("rst s_addr", s_addr, 32'h0);
        chk("rst m_ready", 32'(m_ready), 32'h0);
        chk("rst m_dataIn", m_dataIn, 32'h0);
        chk("rst timeout_err", 32'(timeout_err), 32'h0);
        chk("rst err_id", 32'(err_id), 32'h0);
        next_cycle;
        drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
        res_n = 1'b1;
        settle;
        next_cycle;

        // Single-master read, late ready, then round-robin fairness
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].re, tbl[i].we, tbl[i].io, tbl[i].srdy, tbl[i].sdin);
            settle;
            chk($sformatf("r%0d grant", i), 32'(grant), 32'(tbl[i].grant_e));
            chk($sformatf("r%0d s_re", i), 32'(s_re), 32'(tbl[i].sre_e));
            chk($sformatf("r%0d s_we", i), 32'(s_we), 32'(tbl[i].swe_e));
            chk($sformatf("r%0d s_io", i), 32'(s_io), 32'(tbl[i].sio_e));
            chk($sformatf("r%0d s_addr", i), s_addr, tbl[i].saddr_e);
            chk($sformatf("r%0d m_ready", i), 32'(m_ready), 32'(tbl[i].mrdy_e));
            chk($sformatf("r%0d m_dataIn", i), m_dataIn, tbl[i].mdin_e);
            chk($sformatf("r%0d timeout_err", i), 32'(timeout_err), 32'h0);
            next_cycle;
        end

        // Timeout: master 1 writes, slave never answers
        drive(3'b000, 3'b010, 3'b000, 1'b0, 32'h77);
        next_cycle;
        for (int b = 1; b <= TO; b++) begin
            drive(3'b000, 3'b010, 3'b000, 1'b0, 32'h77);
            settle;
            chk($sformatf("to b%0d grant", b), 32'(grant), 32'h2);
            if (b < TO) begin
                chk($sformatf("to b%0d m_ready", b), 32'(m_ready), 32'h0);
                chk($sformatf("to b%0d timeout_err", b), 32'(timeout_err), 32'h0);
            end else begin
                chk("to m_ready", 32'(m_ready), 32'h2);
                chk("to m_dataIn", m_dataIn, 32'hDEAD_BEEF);
                chk("to timeout_err", 32'(timeout_err), 32'h1);
                chk("to s_we", 32'(s_we), 32'h1);
                chk("to s_dataOut", s_dataOut, 32'hD000_0001);
            end
            next_cycle;
        end
        drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
        settle;
        chk("to gap timeout_err", 32'(timeout_err), 32'h0);
        chk("to gap grant", 32'(grant), 32'h0);
        chk("to err_id", 32'(err_id), 32'h1);
        next_cycle;
        drive(3'b100, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle;
        drive(3'b100, 3'b000, 3'b000, 1'b1, 32'h2222_0002);
        settle;
        chk("after to grant", 32'(grant), 32'h4);
        chk("after to m_ready", 32'(m_ready), 32'h4);
        chk("after to m_dataIn", m_dataIn, 32'h2222_0002);
        next_cycle;
        drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle;

        // Ready arrives in the same cycle the timeout would fire
        drive(3'b001, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle;
        for (int b = 1; b <= TO; b++) begin
            drive(3'b001, 3'b000, 3'b000, (b == TO), (b == TO) ? 32'h3333_0003 : 32'h0);
            settle;
            if (b == TO) begin
                chk("coll m_ready", 32'(m_ready), 32'h1);
                chk("coll m_dataIn", m_dataIn, 32'h3333_0003);
                chk("coll timeout_err", 32'(timeout_err), 32'h0);
            end
            next_cycle;
        end
        drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
        settle;
        chk("coll err_id", 32'(err_id), 32'h1);
        chk("coll gap grant", 32'(grant), 32'h0);
        next_cycle;

        // Abort by master 2, late ready ignored, priority order unchanged
        drive(3'b100, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle;
        drive(3'b100, 3'b000, 3'b000, 1'b0, 32'h0);
        settle;
        chk("abort busy grant", 32'(grant), 32'h4);
        next_cycle;
        drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
        settle;
        chk("abort drop m_ready", 32'(m_ready), 32'h0);
        chk("abort drop s_re", 32'(s_re), 32'h0);
        next_cycle;
        drive(3'b000, 3'b000, 3'b000, 1'b1, 32'h4444);
        settle;
        chk("abort gap grant", 32'(grant), 32'h0);
        chk("abort gap m_ready", 32'(m_ready), 32'h0);
        chk("abort gap m_dataIn", m_dataIn, 32'h0);
        next_cycle;
        drive(3'b101, 3'b000, 3'b000, 1'b1, 32'h4444);
        settle;
        chk("abort idle m_ready", 32'(m_ready), 32'h0);
        chk("abort idle grant", 32'(grant), 32'h0);
        next_cycle;
        drive(3'b101, 3'b000, 3'b000, 1'b1, 32'h55);
        settle;
        chk("abort rr grant", 32'(grant), 32'h4);
        next_cycle;
        drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle;

        // Reset while master 1 owns the bus
        drive(3'b111, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle;
        drive(3'b111, 3'b000, 3'b000, 1'b1, 32'h66);
        settle;
        chk("pre grant0", 32'(grant), 32'h1);
        next_cycle;
        drive(3'b111, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle;
        next_cycle;
        drive(3'b111, 3'b000, 3'b000, 1'b1, 32'h77);
        #1;
        chk("pre-reset grant", 32'(grant), 32'h2);
        #1;
        res_n = 1'b0;
        #1;
        chk("mid-reset s_re", 32'(s_re), 32'h0);
        chk("mid-reset grant", 32'(grant), 32'h0);
        chk("mid-reset m_ready", 32'(m_ready), 32'h0);
        chk("mid-reset m_dataIn", m_dataIn, 32'h0);
        chk("mid-reset err_id", 32'(err_id), 32'h0);
        next_cycle;
        next_cycle;
        drive(3'b111, 3'b000, 3'b000, 1'b0, 32'h0);
        res_n = 1'b1;
        settle;
        chk("post-reset idle grant", 32'(grant), 32'h0);
        next_cycle;
        settle;
        chk("post-reset grant", 32'(grant), 32'h1);
        chk("post-reset s_addr", s_addr, 32'h100);
        chk("post-reset s_re", 32'(s_re), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/db_arbiter.md
# db_arbiter

Parametrised N-master arbiter for the DataBus handshake (`db_re`/`db_we`/`db_io`/`db_addr`/`db_dataOut` out, `db_dataIn`/`db_ready` back). It lets several bus masters (CPU, debug loader, DMA) share one memory interface. Arbitration is round-robin, and the grant is held for the whole transaction. A per-transaction timeout completes a hung access with an error word, so a stalled slave cannot lock up the bus. It sits between the masters and the single memory interface instance.

## Interface
- `NUM_MASTERS`, 2: number of masters, N ≥ 2.
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 1024: BUSY cycles before a forced error completion. 0 disables the timeout.
- `ERR_DATA`, 32'hDEAD_BEEF: value returned on `m_dataIn` on a timeout, truncated to `DATA_W`.
- `clk` in 1: the single clock. All state is updated on the rising edge.
- `res_n` in 1: asynchronous, active-low reset.
- `m_re`, `m_we`, `m_io` in N each: per-master request strobes.
- `m_addr` in N*ADDR_W: master i occupies bits [i*ADDR_W +: ADDR_W].
- `m_dataOut` in N*DATA_W: write data, packed the same way.
- `m_dataIn` out DATA_W: read data, broadcast to all masters.
- `m_ready` out N: completion pulse, one-hot.
- `s_re`, `s_we`, `s_io` out 1: strobes to the slave.
- `s_addr` out ADDR_W, `s_dataOut` out DATA_W: to the slave.
- `s_dataIn` in DATA_W, `s_ready` in 1: from the slave.
- `grant` out N: one-hot current owner, 0 when idle.
- `timeout_err` out 1: one-cycle pulse on a forced completion.
- `err_id` out clog2(N): index of the master that timed out; holds until the next timeout.

## Operation
- Master i requests when `m_re[i] | m_we[i]`. It holds addr, data and strobes stable until it sees `m_ready[i]`.
- Three states: IDLE, BUSY, GAP.
- **IDLE**
  - If any master requests, pick the first requester scanning from `rr_ptr+1` upward, modulo N.
  - Register `grant`, clear the timeout counter, go to BUSY.
  - With no requests, stay in IDLE.
- **BUSY**
  - `s_*` outputs are the granted master's signals, muxed combinationally from registered `grant`.
  - `m_ready[g] = s_ready` and `m_dataIn = s_dataIn`.
  - On `s_ready`: `rr_ptr <= g`, go to GAP.
  - On timeout (counter == TIMEOUT-1 and no `s_ready`):
    - Force `m_ready[g]=1` and `m_dataIn=ERR_DATA`.
    - Pulse `timeout_err`, set `err_id <= g`.
    - `rr_ptr <= g`, go to GAP.
  - If the granted master drops its request without a ready (illegal abort): go to GAP, no ready, `rr_ptr` unchanged.
- **GAP**
  - All `s_*` strobes are 0 and `grant` is 0.
  - Go to IDLE next cycle. This guarantees the slave sees its strobes drop between transactions.
- Outside BUSY:
  - `s_re`/`s_we`/`s_io` are 0.
  - `s_addr`/`s_dataOut` are 0.
  - `m_ready` is 0 and `m_dataIn` is 0.
- Both `re` and `we` asserted by one master are forwarded unchanged. Decoding them is the slave's job.
- Timeout counter: width clog2(TIMEOUT+1). It increments each BUSY cycle without `s_ready` and never wraps. When TIMEOUT=0 the counter and error path are inert.

## Timing
- Reset (async, `res_n`=0):
  - State IDLE, `grant`=0, `rr_ptr`=N-1 (master 0 wins first), counter 0.
  - `timeout_err`=0, `err_id`=0.
  - All outputs 0.
- A request seen in IDLE at cycle t gives `grant` and slave strobes at cycle t+1.
- `m_ready` follows `s_ready` combinationally, with zero added latency on the return path.
- Minimum transaction spacing is 3 cycles: IDLE, BUSY (≥1 cycle), GAP.
- Timeout fires in the TIMEOUT-th BUSY cycle: BUSY lasts exactly TIMEOUT cycles.
- If `s_ready` and the timeout condition occur in the same cycle, the ready wins: normal completion, no error.
- A late `s_ready` in GAP or IDLE is ignored and produces no `m_ready`.
- Reset asserted mid-BUSY drops all strobes immediately (asynchronously). The aborted transaction is not completed.
- A master that keeps requesting after its ready re-enters arbitration at IDLE with lowest priority.

## Test plan
- **Single master:** reset, master 0 read at addr 0x100, slave returns 0x12345678 with `s_ready` on its 2nd BUSY cycle → `m_ready[0]` pulses that cycle, `m_dataIn`=0x12345678, `grant` 01→00 after.
- **Fairness:** N=2, both masters request continuously, slave ready after 1 cycle → grants alternate 0,1,0,1, each separated by GAP+IDLE (3-cycle period).
- **Timeout:** TIMEOUT=8, slave never readies, master 1 writes → 8 BUSY cycles, then `m_ready[1]`=1, `m_dataIn`=0xDEADBEEF, `timeout_err` pulses, `err_id`=1. Next transaction still works.
- **Ready/timeout collision:** TIMEOUT=4, `s_ready` in 4th BUSY cycle → slave data returned, `timeout_err` stays 0.
- **Reset mid-transaction:** `res_n` low during BUSY → `s_re`/`grant`/`m_ready` 0 immediately. After release, master 0 (N=3, all requesting) is granted first.
- **Abort:** granted master drops `m_re` in BUSY before ready → GAP next cycle, no `m_ready`, a late `s_ready` is ignored.
